// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU and an auxiliary master
module dm_arbiter #(
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [1:0]  req_lock,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [5:0]  req_mode,
  input  logic [63:0] req_pc,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] dm_read_addr,
  output logic [31:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_write_enable,
  output logic [2:0]  dm_mode,
  output logic [31:0] dm_curr_pc,
  input  logic [31:0] dm_read_result,
  input  logic        dm_invalid
);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  state_t      state;
  logic        rr_ptr;
  logic [7:0]  starve_cnt;
  logic        both, pick1, g0, g1, gs, any;
  logic [31:0] sel_addr;
  // grant selection: a lock pins the grant to its owner, otherwise round-robin or priority with starvation guard
  always_comb begin
    both      = &req_valid;
    pick1     = (PRIO_MODE == 0) ? rr_ptr : (starve_cnt == SMAX);
    g1        = (state == LOCK1) ? req_valid[1] : (state == LOCK0) ? 1'b0 : both ? pick1 : req_valid[1];
    g0        = (state == LOCK0) ? req_valid[0] : (state == LOCK1) ? 1'b0 : req_valid[0] & ~g1;
    req_ready = rst ? {g1, g0} : 2'b00;
    gs        = req_ready[1];
    any       = |req_ready;
    sel_addr  = gs ? req_addr[63:32] : req_addr[31:0];
    dm_read_addr    = any ? sel_addr : 32'd0;
    dm_write_addr   = any ? sel_addr : 32'd0;
    dm_write_data   = any ? (gs ? req_wdata[63:32] : req_wdata[31:0]) : 32'd0;
    dm_write_enable = any & req_we[gs];
    dm_mode         = any ? (gs ? req_mode[5:3] : req_mode[2:0]) : 3'd0;
    dm_curr_pc      = any ? (gs ? req_pc[63:32] : req_pc[31:0]) : 32'd0;
  end
  // lock state, fairness state and the one-cycle registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      rr_ptr     <= 1'b0;
      starve_cnt <= 8'd0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= 32'd0;
      rsp_fault  <= 1'b0;
    end else begin
      rsp_valid <= req_ready;
      if (any) begin
        rsp_rdata <= dm_read_result;
        rsp_fault <= dm_invalid;
      end
      if (state == ARB && both && any) rr_ptr <= ~gs;
      state <= any ? (req_lock[gs] ? (gs ? LOCK1 : LOCK0) : ARB) : state;
      starve_cnt <= (PRIO_MODE == 0 || !req_valid[1] || req_ready[1]) ? 8'd0 :
                    (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven scoreboard bench for dm_arbiter
module tb_dm_arbiter;
  localparam logic [2:0] DM_W = 3'd1;
  typedef struct {
    logic [1:0]  valid, we, lock;
    logic [31:0] a0, a1, d;
    logic [1:0]  exp_ready;
    logic        exp_we;
  } vec_t;
  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
    logic        f;
  } rsp_t;
  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [63:0] req_addr, req_wdata, req_pc;
  logic [5:0]  req_mode;
  logic [31:0] rsp_rdata, dm_read_addr, dm_write_addr, dm_write_data, dm_curr_pc, dm_rd;
  logic        rsp_fault, dm_write_enable, dm_inv;
  logic [2:0]  dm_mode;
  logic [1:0]  p_ready, p_rsp_valid;
  logic [31:0] p_rsp_rdata, p_ra, p_wa, p_wd, p_pc;
  logic        p_rsp_fault, p_we;
  logic [2:0]  p_mode;
  logic [31:0] mem [16];
  rsp_t        sb [$];
  vec_t        tv [$];
  int          checks = 0, failures = 0;
  logic        mon_en = 1'b0;

  dm_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr), .dm_write_data(dm_write_data),
    .dm_write_enable(dm_write_enable), .dm_mode(dm_mode), .dm_curr_pc(dm_curr_pc),
    .dm_read_result(dm_rd), .dm_invalid(dm_inv)
  );

  dm_arbiter #(.PRIO_MODE(1), .STARVE_MAX(3)) dut_p (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(p_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .req_pc(req_pc), .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata), .rsp_fault(p_rsp_fault),
    .dm_read_addr(p_ra), .dm_write_addr(p_wa), .dm_write_data(p_wd),
    .dm_write_enable(p_we), .dm_mode(p_mode), .dm_curr_pc(p_pc),
    .dm_read_result(32'd0), .dm_invalid(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word-only data memory model: misaligned word accesses are invalid and writes to them are dropped
  assign dm_rd  = mem[dm_read_addr[5:2]];
  assign dm_inv = (dm_mode == DM_W) && (dm_read_addr[1:0] != 2'b00);
  always @(posedge clk) if (dm_write_enable && !dm_inv) mem[dm_write_addr[5:2]] <= dm_write_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] valid, we, lock, input logic [31:0] a0, a1, d,
                              input logic [1:0] exp_ready, input logic exp_we);
    vec_t v;
    v.valid = valid; v.we = we; v.lock = lock; v.a0 = a0; v.a1 = a1; v.d = d;
    v.exp_ready = exp_ready; v.exp_we = exp_we;
    return v;
  endfunction

  // drive at a negedge, check the combinational grant just before the posedge, queue the expected response
  task automatic apply(input vec_t v, input string nm);
    rsp_t        e;
    logic [31:0] a;
    req_valid = v.valid; req_we = v.we; req_lock = v.lock;
    req_addr = {v.a1, v.a0}; req_wdata = {v.d, v.d};
    req_mode = {DM_W, DM_W}; req_pc = 64'h0000_2000_0000_1000;
    #4;
    a = v.exp_ready[1] ? v.a1 : v.a0;
    chk({nm, ".ready"}, 64'(req_ready), 64'(v.exp_ready));
    chk({nm, ".we"}, 64'(dm_write_enable), 64'(v.exp_we));
    chk({nm, ".addr"}, 64'(dm_read_addr), (v.exp_ready != 2'b00) ? 64'(a) : 64'd0);
    if (v.exp_ready != 2'b00) begin
      e.v = v.exp_ready;
      e.d = mem[a[5:2]];
      e.f = (a[1:0] != 2'b00);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  // response scoreboard: one response per grant, exactly one cycle later; silence otherwise
  always @(negedge clk) begin
    rsp_t e;
    if (mon_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e.v));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.d));
        chk("rsp_fault", 64'(rsp_fault), 64'(e.f));
      end else chk("rsp_idle", 64'(rsp_valid), 64'd0);
    end
  end

  initial begin
    logic [1:0] pe [8];
    logic [1:0] prev;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1111_1111 * i;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1234_5678;
    rst = 1'b0; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_mode = '0; req_pc = '0;
    @(negedge clk);
    apply(mk(2'b11, 2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0), "reset");
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset.rsp_fault", 64'(rsp_fault), 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b10, 1'b0));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b10, 1'b0));
    tv.push_back(mk(2'b10, 2'b00, 2'b10, 32'h10, 32'h20, 32'h0, 2'b10, 1'b0));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0));
    tv.push_back(mk(2'b11, 2'b10, 2'b00, 32'h10, 32'h20, 32'hCAFE_F00D, 2'b10, 1'b1));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h20, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b01, 2'b01, 2'b00, 32'h13, 32'h20, 32'h5555_5555, 2'b01, 1'b1));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0));
    tv.push_back(mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0));
    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("vec%0d", i));
    chk("misaligned_write_dropped", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);
    apply(mk(2'b01, 2'b00, 2'b01, 32'h10, 32'h20, 32'h0, 2'b01, 1'b0), "lock0");
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    #1 chk("midlock_reset.rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    apply(mk(2'b10, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0), "in_reset");
    rst = 1'b1;
    apply(mk(2'b10, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b10, 1'b0), "post_reset_p1");
    apply(mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0), "idle");
    mon_en = 1'b0;
    apply(mk(2'b00, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 2'b00, 1'b0), "idle");
    pe = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    prev = 2'b00;
    req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00; req_addr = {32'h20, 32'h10};
    for (int i = 0; i < 8; i++) begin
      #4 chk($sformatf("prio.ready%0d", i), 64'(p_ready), 64'(pe[i]));
      chk($sformatf("prio.rsp%0d", i), 64'(p_rsp_valid), 64'(prev));
      prev = pe[i];
      @(negedge clk);
    end
    chk("prio.rsp_last", 64'(p_rsp_valid), 64'(prev));
    req_valid = 2'b00;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
